picomem_arbiter_2_1: RTL and testbench

- Two-master to one-slave arbiter for the PicoMem valid/ready bus.
- Shares one downstream slave port (e.g. the SRAM / peripheral mux input) between the CPU (m0) and a second bus master such as a DMA or video fetch engine (m1).
- Grants one master at a time and holds the grant until the slave completes the transfer.
- Selectable round-robin or fixed-priority policy, with optional watchdog timeout.

---
 rtl/picomem_pkg.sv | 23 ++
 rtl/picomem_rr_pick.sv | 22 ++
 rtl/picomem_arbiter_2_1.sv | 142 ++++++++++++++
 tb/tb_picomem_arbiter_2_1.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/picomem_pkg.sv
// Shared PicoMem bus definitions: widths, request bundle, arbiter state
// encoding and arbitration policy codes.
package picomem_pkg;

    localparam int PICOMEM_AW = 32;
    localparam int PICOMEM_DW = 32;
    localparam int PICOMEM_SW = 4;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [PICOMEM_AW-1:0] addr;
        logic [PICOMEM_DW-1:0] wdata;
        logic [PICOMEM_SW-1:0] wstrb;
    } picomem_req_t;

endpackage

// File: rtl/picomem_rr_pick.sv
// Two-input winner selection: round-robin on last_grant or fixed m0 priority.
// Purely combinational; win is one-hot, or zero when nobody requests.
module picomem_rr_pick
    import picomem_pkg::*;
#(
    parameter int ARB_MODE = ARB_MODE_RR
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        // last_grant=1 means m1 owned the bus last, so m0 takes the tie
        if (req == 2'b11) begin
            if (ARB_MODE == ARB_MODE_FIXED || last_grant) win = 2'b01;
            else                                          win = 2'b10;
        end
    end

endmodule

// File: rtl/picomem_arbiter_2_1.sv
// Two-master to one-slave PicoMem arbiter; grant is held until the slave completes.
// Optional watchdog enabled by defining PICOMEM_ARB_TIMEOUT_EN.
module picomem_arbiter_2_1
    import picomem_pkg::*;
#(
    parameter int                    ARB_MODE       = ARB_MODE_RR,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter logic [PICOMEM_DW-1:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  m0_valid,
    input  logic [PICOMEM_AW-1:0] m0_addr,
    input  logic [PICOMEM_DW-1:0] m0_wdata,
    input  logic [PICOMEM_SW-1:0] m0_wstrb,
    output logic                  m0_ready,
    output logic [PICOMEM_DW-1:0] m0_rdata,
    input  logic                  m1_valid,
    input  logic [PICOMEM_AW-1:0] m1_addr,
    input  logic [PICOMEM_DW-1:0] m1_wdata,
    input  logic [PICOMEM_SW-1:0] m1_wstrb,
    output logic                  m1_ready,
    output logic [PICOMEM_DW-1:0] m1_rdata,
    output logic                  s_valid,
    output logic [PICOMEM_AW-1:0] s_addr,
    output logic [PICOMEM_DW-1:0] s_wdata,
    output logic [PICOMEM_SW-1:0] s_wstrb,
    input  logic                  s_ready,
    input  logic [PICOMEM_DW-1:0] s_rdata,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  timeout_err
);

    arb_state_e             state_q, state_d;
    logic [1:0]             grant_q, grant_d, win;
    logic                   last_q, last_d;
    logic                   owner, grant_valid, xfer_done, to_hit;
    logic [PICOMEM_DW-1:0]  resp;
    picomem_req_t           req0, req1, req_sel;

    picomem_rr_pick #(.ARB_MODE(ARB_MODE)) u_pick (
        .req        ({m1_valid, m0_valid}),
        .last_grant (last_q),
        .win        (win)
    );

    assign req0        = {m0_addr, m0_wdata, m0_wstrb};
    assign req1        = {m1_addr, m1_wdata, m1_wstrb};
    assign owner       = grant_q[1];
    assign req_sel     = owner ? req1 : req0;
    assign grant_valid = (state_q == ARB_GRANT) && (owner ? m1_valid : m0_valid);
    assign xfer_done   = grant_valid && s_ready;

    // Timeout withdraws s_valid in the same cycle it answers the master
    assign s_valid = grant_valid && !to_hit;
    assign s_addr  = req_sel.addr;
    assign s_wdata = req_sel.wdata;
    assign s_wstrb = req_sel.wstrb;
    assign grant   = grant_q;
    assign busy    = (state_q == ARB_GRANT);

`ifdef PICOMEM_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    logic        err_q;

    assign to_hit      = grant_valid && !s_ready && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    assign timeout_err = err_q;
    assign resp        = to_hit ? TIMEOUT_RDATA : s_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ARB_IDLE) cnt_q <= '0;
            else if (!s_ready)       cnt_q <= cnt_q + 16'd1;
            if (to_hit)              err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_params;

    assign to_hit                = 1'b0;
    assign timeout_err           = 1'b0;
    assign resp                  = s_rdata;
    assign unused_timeout_params = ^{TIMEOUT_RDATA, TIMEOUT_CYCLES};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARB_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;
        case (state_q)
            ARB_IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d = ARB_GRANT;
                    grant_d = win;
                end
            end
            ARB_GRANT: begin
                if (owner) begin
                    m1_ready = xfer_done || to_hit;
                    m1_rdata = resp;
                end else begin
                    m0_ready = xfer_done || to_hit;
                    m0_rdata = resp;
                end
                if (xfer_done || to_hit) begin
                    state_d = ARB_IDLE;
                    grant_d = 2'b00;
                    last_d  = owner;
                end else if (!grant_valid) begin
                    // master abandoned its request: release without touching fairness
                    state_d = ARB_IDLE;
                    grant_d = 2'b00;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_picomem_arbiter_2_1.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter run side by side,
// each with its own master request counters and latency-programmable slave.
module tb_picomem_arbiter_2_1;

    localparam int NEVER = 100000;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          lat = 0;

    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [31:0] s_rdata;
    int          issued [2][2];
    int          done [2][2];
    int          scnt [2];

    logic        vld [2][2];
    logic        rdy [2][2];
    logic [31:0] rdt [2][2];
    logic        sv [2];
    logic [31:0] sa [2];
    logic [31:0] swd [2];
    logic [3:0]  sws [2];
    logic        s_rdy [2];
    logic [1:0]  gnt [2];
    logic        bsy [2];
    logic        terr [2];

    exp_t        q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Masters hold valid until each issued request has seen its ready
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) vld[d][m] = (issued[d][m] != done[d][m]);
            s_rdy[d] = (scnt[d] >= lat);
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 2; m++) if (rdy[d][m]) done[d][m] <= done[d][m] + 1;
            scnt[d] <= (sv[d] && !s_rdy[d]) ? scnt[d] + 1 : 0;
        end
    end

    picomem_arbiter_2_1 #(.ARB_MODE(0), .TIMEOUT_CYCLES(8)) u_rr (
        .clk(clk), .resetn(resetn),
        .m0_valid(vld[0][0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]),
        .m0_ready(rdy[0][0]), .m0_rdata(rdt[0][0]),
        .m1_valid(vld[0][1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]),
        .m1_ready(rdy[0][1]), .m1_rdata(rdt[0][1]),
        .s_valid(sv[0]), .s_addr(sa[0]), .s_wdata(swd[0]), .s_wstrb(sws[0]),
        .s_ready(s_rdy[0]), .s_rdata(s_rdata),
        .grant(gnt[0]), .busy(bsy[0]), .timeout_err(terr[0])
    );

    picomem_arbiter_2_1 #(.ARB_MODE(1), .TIMEOUT_CYCLES(8)) u_fx (
        .clk(clk), .resetn(resetn),
        .m0_valid(vld[1][0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]),
        .m0_ready(rdy[1][0]), .m0_rdata(rdt[1][0]),
        .m1_valid(vld[1][1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]),
        .m1_ready(rdy[1][1]), .m1_rdata(rdt[1][1]),
        .s_valid(sv[1]), .s_addr(sa[1]), .s_wdata(swd[1]), .s_wstrb(sws[1]),
        .s_ready(s_rdy[1]), .s_rdata(s_rdata),
        .grant(gnt[1]), .busy(bsy[1]), .timeout_err(terr[1])
    );

    task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    task automatic expect_xfer(int d, int m, logic [31:0] rd, int c);
        exp_t e;
        e.m = m;
        e.rdata = rd;
        e.cyc = c;
        q[d].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: slave-side passthrough while s_valid, completion order/data/cycle on ready
    always @(negedge clk) begin
        if (resetn) begin
            for (int d = 0; d < 2; d++) begin
                if (sv[d]) begin
                    if (q[d].size() == 0) check("s_valid_unexpected", d, 1, 0);
                    else begin
                        check("s_addr", d, sa[d], addr[q[d][0].m]);
                        check("s_wdata", d, swd[d], wdata[q[d][0].m]);
                        check("s_wstrb", d, {28'd0, sws[d]}, {28'd0, wstrb[q[d][0].m]});
                        check("idle_master_rdata", d, rdt[d][1 - q[d][0].m], 0);
                    end
                end
                for (int m = 0; m < 2; m++) begin
                    if (rdy[d][m]) begin
                        if (q[d].size() == 0) check("ready_unexpected", d, m, 32'hFFFF_FFFF);
                        else begin
                            exp_t e;
                            e = q[d].pop_front();
                            check("ready_master", d, m, e.m);
                            check("ready_rdata", d, rdt[d][m], e.rdata);
                            if (e.cyc >= 0) check("ready_cycle", d, cyc, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        for (int m = 0; m < 2; m++) begin
            addr[m] = '0; wdata[m] = '0; wstrb[m] = '0;
            for (int d = 0; d < 2; d++) issued[d][m] = 0;
        end
        s_rdata = '0;
        lat = 0;

        // Reset state
        repeat (2) tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_grant", d, gnt[d], 0);
            check("rst_busy", d, bsy[d], 0);
            check("rst_s_valid", d, sv[d], 0);
            check("rst_ready", d, {rdy[d][1], rdy[d][0]}, 0);
            check("rst_timeout_err", d, terr[d], 0);
        end
        resetn = 1'b1;
        tick();

        // Single m0 read, slave answers on the 4th GRANT cycle
        lat = 3;
        s_rdata = 32'h1234_5678;
        addr[0] = 32'h4000_0010;
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            issued[d][0]++;
            expect_xfer(d, 0, 32'h1234_5678, c + 4);
        end
        #1;
        for (int d = 0; d < 2; d++) check("s_valid_req_cycle", d, sv[d], 0);
        tick();
        for (int d = 0; d < 2; d++) check("s_valid_next_cycle", d, sv[d], 1);
        repeat (5) tick();

        // Both masters request twice, zero-latency slave
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        lat = 0;
        s_rdata = 32'h0000_1111;
        addr[0] = 32'h0000_1000; wdata[0] = 32'h0101_0101; wstrb[0] = 4'hF;
        addr[1] = 32'h0000_2000; wdata[1] = 32'h0202_0202; wstrb[1] = 4'h0;
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            issued[d][0] += 2;
            issued[d][1] += 2;
        end
        expect_xfer(0, 0, 32'h0000_1111, c + 1);
        expect_xfer(0, 1, 32'h0000_1111, c + 3);
        expect_xfer(0, 0, 32'h0000_1111, c + 5);
        expect_xfer(0, 1, 32'h0000_1111, c + 7);
        expect_xfer(1, 0, 32'h0000_1111, c + 1);
        expect_xfer(1, 0, 32'h0000_1111, c + 3);
        expect_xfer(1, 1, 32'h0000_1111, c + 5);
        expect_xfer(1, 1, 32'h0000_1111, c + 7);
        tick();
        #1;
        check("rr_grant_first", 0, gnt[0], 2'b01);
        tick();
        #1;
        check("rr_grant_gap", 0, gnt[0], 2'b00);
        tick();
        #1;
        check("rr_grant_second", 0, gnt[0], 2'b10);
        check("fx_grant_second", 1, gnt[1], 2'b01);
        repeat (6) tick();

        // m1 write while m0 idle; busy only during GRANT
        lat = 2;
        s_rdata = 32'h5555_AAAA;
        addr[1] = 32'h8000_0040; wdata[1] = 32'hA5A5_0F0F; wstrb[1] = 4'b0011;
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            issued[d][1]++;
            expect_xfer(d, 1, 32'h5555_AAAA, c + 3);
        end
        for (int k = 0; k < 5; k++) begin
            #1;
            for (int d = 0; d < 2; d++) check("busy_window", d, bsy[d], (k >= 1 && k <= 3) ? 1 : 0);
            tick();
        end
        repeat (2) tick();

        // Async reset in the middle of a stalled transfer
        lat = NEVER;
        s_rdata = 32'hC0FF_EE00;
        addr[0] = 32'h0000_0100; wdata[0] = 32'h1357_9BDF; wstrb[0] = 4'hF;
        for (int d = 0; d < 2; d++) begin
            issued[d][0]++;
            expect_xfer(d, 0, 32'hC0FF_EE00, -1);
        end
        tick();
        tick();
        #1;
        for (int d = 0; d < 2; d++) check("pre_reset_s_valid", d, sv[d], 1);
        resetn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("async_rst_s_valid", d, sv[d], 0);
            check("async_rst_grant", d, gnt[d], 0);
            check("async_rst_busy", d, bsy[d], 0);
        end
        tick();
        tick();
        lat = 1;
        resetn = 1'b1;
        c = cyc;
        for (int d = 0; d < 2; d++) q[d][0].cyc = c + 2;
        repeat (4) tick();

`ifdef PICOMEM_ARB_TIMEOUT_EN
        // Hung slave: watchdog answers on the 8th GRANT cycle
        lat = NEVER;
        s_rdata = 32'h7777_7777;
        addr[0] = 32'h0000_0200; wdata[0] = 32'h0; wstrb[0] = 4'h0;
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            issued[d][0]++;
            expect_xfer(d, 0, 32'hDEAD_BEEF, c + 8);
        end
        repeat (8) tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            check("timeout_s_valid_low", d, sv[d], 0);
            check("timeout_err_before", d, terr[d], 0);
        end
        tick();
        for (int d = 0; d < 2; d++) check("timeout_err_set", d, terr[d], 1);
        lat = 0;
        addr[1] = 32'h0000_0300; wdata[1] = 32'h2468_ACE0; wstrb[1] = 4'hC;
        c = cyc;
        for (int d = 0; d < 2; d++) begin
            issued[d][1]++;
            expect_xfer(d, 1, 32'h7777_7777, c + 1);
        end
        repeat (3) tick();
        for (int d = 0; d < 2; d++) check("timeout_err_sticky", d, terr[d], 1);
`else
        for (int d = 0; d < 2; d++) check("timeout_err_tied", d, terr[d], 0);
`endif

        tick();
        for (int d = 0; d < 2; d++) check("scoreboard_drained", d, q[d].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
